// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready handshake; one 2^k shift per stage.
// Define BSH_FLAGS_EN to add the out_carry / out_zero flag outputs.
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSH_FLAGS_EN
  ,
  output logic             out_carry,
  output logic             out_zero
`endif
);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // One stage's conditional shift by s; SRA stays correct stage by stage because the MSB never changes.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [2:0] m,
                                                  input logic en,
                                                  input int s);
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (m)
        MODE_SLL: r = d << s;
        MODE_SRL: r = d >> s;
        MODE_SRA: r = $signed(d) >>> s;
        MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
        MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
        default:  r = d;
      endcase
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic             advance_s;
  logic [SHW-1:0]   valid_r;
  logic [WIDTH-1:0] data_r    [SHW];
  logic [WIDTH-1:0] data_nx_s [SHW];
  logic [2:0]       mode_r    [SHW-1];
  logic [SHW-1:0]   amt_r     [SHW-1];
  logic [SHW-1:0]   amt_nx_s  [SHW-1];

  assign advance_s = ~valid_r[SHW-1] | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = valid_r[SHW-1];
  assign out_data  = data_r[SHW-1];

  // Next value of every stage; stage k consumes the amount bit that was shifted down to position 0.
  always_comb begin
    data_nx_s[0] = shift_step(in_data, in_mode, in_amt[0], 1);
    amt_nx_s[0]  = {1'b0, in_amt[SHW-1:1]};
    for (int k = 1; k < SHW; k++) begin
      data_nx_s[k] = shift_step(data_r[k-1], mode_r[k-1], amt_r[k-1][0], 1 << k);
    end
    for (int k = 1; k < SHW - 1; k++) begin
      amt_nx_s[k] = {1'b0, amt_r[k-1][SHW-1:1]};
    end
  end

  // Pipeline registers: every stage moves together on advance and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {SHW{1'b0}};
      for (int k = 0; k < SHW; k++) data_r[k] <= {WIDTH{1'b0}};
      for (int k = 0; k < SHW - 1; k++) begin
        mode_r[k] <= 3'b000;
        amt_r[k]  <= {SHW{1'b0}};
      end
    end else if (advance_s) begin
      valid_r <= {valid_r[SHW-2:0], in_valid};
      for (int k = 0; k < SHW; k++) data_r[k] <= data_nx_s[k];
      mode_r[0] <= in_mode;
      for (int k = 1; k < SHW - 1; k++) mode_r[k] <= mode_r[k-1];
      for (int k = 0; k < SHW - 1; k++) amt_r[k] <= amt_nx_s[k];
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef BSH_FLAGS_EN
  logic [SHW-1:0] carry_r;
  logic           carry_nx_s;
  logic           zero_r;
  logic [SHW-1:0] idx_left_s;
  logic [SHW-1:0] idx_right_s;

  // WIDTH is a power of two, so WIDTH-amt wraps correctly in SHW bits.
  assign idx_left_s  = {SHW{1'b0}} - in_amt;
  assign idx_right_s = in_amt - {{(SHW-1){1'b0}}, 1'b1};

  // Carry is the last bit to cross the word boundary, decided once at accept.
  always_comb begin
    carry_nx_s = 1'b0;
    if (in_amt == {SHW{1'b0}}) begin
      carry_nx_s = 1'b0;
    end else begin
      case (in_mode)
        MODE_SLL, MODE_ROL:           carry_nx_s = in_data[idx_left_s];
        MODE_SRL, MODE_SRA, MODE_ROR: carry_nx_s = in_data[idx_right_s];
        default:                      carry_nx_s = 1'b0;
      endcase
    end
  end

  // Flag registers follow the data pipe with identical stall behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_r <= {SHW{1'b0}};
      zero_r  <= 1'b0;
    end else if (advance_s) begin
      carry_r <= {carry_r[SHW-2:0], carry_nx_s};
      zero_r  <= (data_nx_s[SHW-1] == {WIDTH{1'b0}});
    end else begin
      zero_r  <= zero_r;
    end
  end

  assign out_carry = carry_r[SHW-1];
  assign out_zero  = zero_r;
`endif

endmodule
